one_to_sixteen_deserializer_fsm: RTL and testbench

Receive-side counterpart of the 16-to-1 serial transmitter. It samples a serial bit stream, LSB first, on every clock edge while the active-low select `ss` is held low, and assembles 16 bits into a parallel word. It presents the word with a `data_valid`/`ack` handshake and flags short frames and unconsumed words. It sits between the serial link and the parallel consumer logic.

---
 rtl/one_to_sixteen_deserializer_fsm.sv | 113 +++++++++++
 tb/tb_one_to_sixteen_deserializer_fsm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/one_to_sixteen_deserializer_fsm.sv
// Serial-to-parallel receiver: shifts in 16 LSB-first bits while ss is low and
// presents each completed word through a data_valid/ack handshake.
module one_to_sixteen_deserializer_fsm (
    input  logic        clock,
    input  logic        reset,
    input  logic        ss,
    input  logic        data_input,
    input  logic        ack,
    output logic [15:0] data_output,
    output logic        data_valid,
    output logic        overrun,
    output logic        frame_error,
    output logic        busy,
    output logic [3:0]  bit_count,
    output logic [1:0]  y_Q,
    output logic [15:0] allOfDataIn
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01
    } state_t;

    state_t      r_state,       r_state_next;
    logic [3:0]  r_bit_count,   r_bit_count_next;
    logic [15:0] r_shift,       r_shift_next;
    logic [15:0] r_data_out,    r_data_out_next;
    logic        r_valid,       r_valid_next;
    logic        r_overrun,     r_overrun_next;
    logic        r_frame_error, r_frame_error_next;
    logic [15:0] w_shifted;

    assign w_shifted = {data_input, r_shift[15:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bit_count   <= 4'd0;
            r_shift       <= 16'd0;
            r_data_out    <= 16'd0;
            r_valid       <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= r_state_next;
            r_bit_count   <= r_bit_count_next;
            r_shift       <= r_shift_next;
            r_data_out    <= r_data_out_next;
            r_valid       <= r_valid_next;
            r_overrun     <= r_overrun_next;
            r_frame_error <= r_frame_error_next;
        end
    end

    always_comb begin
        r_state_next       = r_state;
        r_bit_count_next   = r_bit_count;
        r_shift_next       = r_shift;
        r_data_out_next    = r_data_out;
        r_valid_next       = r_valid;
        r_overrun_next     = r_overrun;
        r_frame_error_next = 1'b0;

        // ack is applied first so a word completing on the same edge overrides it
        if (ack) begin
            r_valid_next   = 1'b0;
            r_overrun_next = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (!ss) begin
                    r_shift_next     = w_shifted;
                    r_bit_count_next = 4'd1;
                    r_state_next     = SHIFT;
                end else begin
                    r_bit_count_next = 4'd0;
                end
            end
            SHIFT: begin
                if (!ss) begin
                    r_shift_next = w_shifted;
                    if (r_bit_count == 4'd15) begin
                        r_data_out_next  = w_shifted;
                        r_valid_next     = 1'b1;
                        if (r_valid && !ack)
                            r_overrun_next = 1'b1;
                        r_bit_count_next = 4'd0;
                        r_state_next     = IDLE;
                    end else begin
                        r_bit_count_next = r_bit_count + 4'd1;
                    end
                end else begin
                    // short frame: drop the partial word, keep the last good one
                    r_bit_count_next   = 4'd0;
                    r_state_next       = IDLE;
                    r_frame_error_next = 1'b1;
                end
            end
            default: begin
                r_state_next = IDLE;
            end
        endcase
    end

    assign data_output = r_data_out;
    assign data_valid  = r_valid;
    assign overrun     = r_overrun;
    assign frame_error = r_frame_error;
    assign busy        = (r_state == SHIFT);
    assign bit_count   = r_bit_count;
    assign y_Q         = r_state;
    assign allOfDataIn = r_shift;
endmodule

// File: tb/tb_one_to_sixteen_deserializer_fsm.sv
// Scoreboard bench for the 16-bit deserializer: stimulus queues expected words,
// a monitor pops and compares them at each word completion.
module tb_one_to_sixteen_deserializer_fsm;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ss = 1'b1;
    logic        data_input = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] data_output;
    logic        data_valid;
    logic        overrun;
    logic        frame_error;
    logic        busy;
    logic [3:0]  bit_count;
    logic [1:0]  y_Q;
    logic [15:0] allOfDataIn;

    typedef struct {
        logic [15:0] data;
        logic        valid;
        logic        ovr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    one_to_sixteen_deserializer_fsm dut (
        .clock       (clock),
        .reset       (reset),
        .ss          (ss),
        .data_input  (data_input),
        .ack         (ack),
        .data_output (data_output),
        .data_valid  (data_valid),
        .overrun     (overrun),
        .frame_error (frame_error),
        .busy        (busy),
        .bit_count   (bit_count),
        .y_Q         (y_Q),
        .allOfDataIn (allOfDataIn)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n, input logic a);
        ss = 1'b1;
        ack = a;
        tick();
        ack = 1'b0;
        for (int i = 1; i < n; i++) tick();
    endtask

    // Sends 16 bits LSB first; ack is raised on bit index ack_idx (-1: never).
    task automatic send_word(input logic [15:0] w, input int ack_idx, input logic exp_ovr);
        exp_t e;
        e.data  = w;
        e.valid = 1'b1;
        e.ovr   = exp_ovr;
        sb.push_back(e);
        for (int i = 0; i < 16; i++) begin
            ss = 1'b0;
            data_input = w[i];
            ack = (i == ack_idx);
            tick();
        end
        ack = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ss = 1'b0;
            data_input = w[i];
            tick();
        end
    endtask

    // Monitor: a word completes on an edge where the DUT was in SHIFT with
    // bit_count 15 and ss low (reset not asserted).
    initial begin
        exp_t e;
        logic [1:0] p_state = 2'b00;
        logic [3:0] p_cnt   = 4'd0;
        logic       p_ss    = 1'b1;
        logic       p_rst   = 1'b1;
        forever begin
            @(negedge clock);
            if (p_state == 2'b01 && p_cnt == 4'd15 && !p_ss && !p_rst) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", data_output);
                end else begin
                    e = sb.pop_front();
                    $display("word 0x%04h completed", e.data);
                    check("word_data",    data_output, e.data);
                    check("word_valid",   data_valid,  e.valid);
                    check("word_overrun", overrun,     e.ovr);
                end
            end
            p_state = y_Q;
            p_cnt   = bit_count;
            p_ss    = ss;
            p_rst   = reset;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        check("rst_state",  y_Q,         2'b00);
        check("rst_count",  bit_count,   4'd0);
        check("rst_shift",  allOfDataIn, 16'h0000);
        check("rst_dout",   data_output, 16'h0000);
        check("rst_valid",  data_valid,  1'b0);
        check("rst_ovr",    overrun,     1'b0);
        check("rst_ferr",   frame_error, 1'b0);
        check("rst_busy",   busy,        1'b0);
        reset = 1'b0;
        idle(2, 1'b0);

        // single word
        send_word(16'hA5C3, -1, 1'b0);
        ss = 1'b1;
        check("a5c3_busy", busy, 1'b0);
        idle(1, 1'b1);
        check("ack_clears_valid", data_valid, 1'b0);
        idle(2, 1'b0);

        // back-to-back, ack on first bit of second word
        send_word(16'h1234, -1, 1'b0);
        send_word(16'hFFFF, 0, 1'b0);
        idle(1, 1'b1);

        // back-to-back without ack -> overrun
        send_word(16'h0F0F, -1, 1'b0);
        send_word(16'hBEEF, -1, 1'b1);
        ss = 1'b1;
        check("ovr_set", overrun, 1'b1);
        idle(1, 1'b1);
        check("ovr_ack_valid", data_valid, 1'b0);
        check("ovr_ack_ovr",   overrun,    1'b0);
        idle(2, 1'b0);

        // short frame after 7 bits
        send_bits(16'h007F, 7);
        check("short_busy", busy, 1'b1);
        idle(1, 1'b0);
        check("ferr_pulse", frame_error, 1'b1);
        check("ferr_count", bit_count,   4'd0);
        check("ferr_dout",  data_output, 16'hBEEF);
        check("ferr_valid", data_valid,  1'b0);
        idle(1, 1'b0);
        check("ferr_one_cycle", frame_error, 1'b0);
        send_word(16'h5A5A, -1, 1'b0);
        idle(2, 1'b0);

        // reset mid-word
        send_bits(16'h03FF, 10);
        reset = 1'b1;
        tick();
        check("midrst_dout",  data_output, 16'h0000);
        check("midrst_valid", data_valid,  1'b0);
        check("midrst_count", bit_count,   4'd0);
        check("midrst_shift", allOfDataIn, 16'h0000);
        check("midrst_state", y_Q,         2'b00);
        reset = 1'b0;
        send_word(16'h8001, -1, 1'b0);

        // ack on the same edge as the 16th bit while valid
        send_word(16'h3C3C, 15, 1'b0);
        ss = 1'b1;
        idle(1, 1'b0);
        check("ackedge_valid", data_valid, 1'b1);
        check("ackedge_ovr",   overrun,    1'b0);
        check("clean_end_ferr", frame_error, 1'b0);
        idle(4, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
